// File: rtl/issue_scoreboard_if.sv
// Issue scoreboard bus: two candidate slots, unit completions, flush, grants/stall/kill.
// Latency: none, this is a wiring bundle.
// Backpressure: stall is the only hold signal and is driven by the scoreboard side.
interface issue_scoreboard_if #(
  parameter int AW     = 5,
  parameter int PERF_W = 32
);
  logic              flush;
  // slot 0 candidate
  logic              s0_valid;
  logic              s0_wren;
  logic              s0_fwren;
  logic [AW-1:0]     s0_waddr;
  logic              s0_rden1;
  logic              s0_rden2;
  logic              s0_frden1;
  logic              s0_frden2;
  logic              s0_frden3;
  logic [AW-1:0]     s0_raddr1;
  logic [AW-1:0]     s0_raddr2;
  logic [AW-1:0]     s0_raddr3;
  logic              s0_div;
  logic              s0_fpu;
  // slot 1 candidate
  logic              s1_valid;
  logic              s1_wren;
  logic              s1_fwren;
  logic [AW-1:0]     s1_waddr;
  logic              s1_rden1;
  logic              s1_rden2;
  logic              s1_frden1;
  logic              s1_frden2;
  logic              s1_frden3;
  logic [AW-1:0]     s1_raddr1;
  logic [AW-1:0]     s1_raddr2;
  logic [AW-1:0]     s1_raddr3;
  logic              s1_div;
  logic              s1_fpu;
  // long-latency unit completions
  logic              div_done;
  logic              fpu_done;
  // scoreboard decisions
  logic              grant0;
  logic              grant1;
  logic              stall;
  logic              div_kill;
  logic              fpu_kill;
  logic [PERF_W-1:0] stall_cycles;
  logic              wdt_error;

  // hazard buffer / execute side
  modport master (
    output flush,
    output s0_valid, s0_wren, s0_fwren, s0_waddr, s0_rden1, s0_rden2,
    output s0_frden1, s0_frden2, s0_frden3, s0_raddr1, s0_raddr2, s0_raddr3,
    output s0_div, s0_fpu,
    output s1_valid, s1_wren, s1_fwren, s1_waddr, s1_rden1, s1_rden2,
    output s1_frden1, s1_frden2, s1_frden3, s1_raddr1, s1_raddr2, s1_raddr3,
    output s1_div, s1_fpu,
    output div_done, fpu_done,
    input  grant0, grant1, stall, div_kill, fpu_kill, stall_cycles, wdt_error
  );

  // scoreboard side
  modport slave (
    input  flush,
    input  s0_valid, s0_wren, s0_fwren, s0_waddr, s0_rden1, s0_rden2,
    input  s0_frden1, s0_frden2, s0_frden3, s0_raddr1, s0_raddr2, s0_raddr3,
    input  s0_div, s0_fpu,
    input  s1_valid, s1_wren, s1_fwren, s1_waddr, s1_rden1, s1_rden2,
    input  s1_frden1, s1_frden2, s1_frden3, s1_raddr1, s1_raddr2, s1_raddr3,
    input  s1_div, s1_fpu,
    input  div_done, fpu_done,
    output grant0, grant1, stall, div_kill, fpu_kill, stall_cycles, wdt_error
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order dual-issue scoreboard: multi-cycle RAW/WAW interlock for divider and FPU ops.
// Latency: grants/stall/kills are combinational; pending/unit state updates on the next edge.
// Backpressure: stall holds the hazard buffer whenever a valid slot is not granted.
// Optional: define ISSUE_SCOREBOARD_WATCHDOG_EN to build per-unit busy watchdogs (wdt_error).
module issue_scoreboard #(
  parameter int NREGS     = 32,
  parameter int AW        = $clog2(NREGS),
  parameter int PERF_W    = 32,
  parameter int WDT_LIMIT = 1024
) (
  input  logic              i_clock,
  input  logic              i_reset,
  issue_scoreboard_if.slave io_sb
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} unit_state_t;

  // integer register 0 is hard-wired and can never be a real dependency
  localparam logic [NREGS-1:0] X0_MASK = {{(NREGS-1){1'b1}}, 1'b0};

  unit_state_t       r_div_state, w_div_state_nxt;
  unit_state_t       r_fpu_state, w_fpu_state_nxt;
  logic [NREGS-1:0]  r_int_pend, r_fp_pend;
  logic [NREGS-1:0]  w_int_pend_nxt, w_fp_pend_nxt;
  logic [NREGS-1:0]  w_clr_int, w_clr_fp, w_wdt_clr_int, w_wdt_clr_fp;
  logic [NREGS-1:0]  w_set_int, w_set_fp;
  logic [NREGS-1:0]  w_ip_eff, w_fp_eff;
  logic [AW-1:0]     r_div_dest, r_fpu_dest;
  logic              r_div_wi, r_div_wf, r_fpu_wi, r_fpu_wf;
  logic [PERF_W-1:0] r_stall_cycles;
  logic              w_flush;
  logic              w_div_busy, w_fpu_busy, w_div_done, w_fpu_done;
  logic              w_div_free, w_fpu_free;
  logic              w_div_wdt_fire, w_fpu_wdt_fire;
  logic              w_blocked0, w_blocked1, w_grant0, w_grant1, w_stall;
  logic              w_s0_long, w_pair_int, w_pair_fp, w_same_unit;
  logic              w_div_issue, w_fpu_issue, w_div_from_s0, w_fpu_from_s0;

  // A slot is held if a source or destination is still owned by an in-flight
  // long op, or if the unit it needs cannot accept a new op this cycle.
  function automatic logic f_blocked(
    input logic [NREGS-1:0] ip, input logic [NREGS-1:0] fp,
    input logic rden1, input logic rden2,
    input logic frden1, input logic frden2, input logic frden3,
    input logic wren, input logic fwren,
    input logic [AW-1:0] ra1, input logic [AW-1:0] ra2,
    input logic [AW-1:0] ra3, input logic [AW-1:0] wa,
    input logic div, input logic fpu, input logic div_free, input logic fpu_free);
    return (rden1 & ip[ra1]) | (rden2 & ip[ra2]) |
           (frden1 & fp[ra1]) | (frden2 & fp[ra2]) | (frden3 & fp[ra3]) |
           (wren & ip[wa]) | (fwren & fp[wa]) |
           (div & ~div_free) | (fpu & ~fpu_free);
  endfunction

  assign w_flush    = io_sb.flush;
  assign w_div_busy = (r_div_state == ST_BUSY);
  assign w_fpu_busy = (r_fpu_state == ST_BUSY);
  // a completion only counts for a busy unit and is dropped while flushing
  assign w_div_done = io_sb.div_done & w_div_busy & ~w_flush;
  assign w_fpu_done = io_sb.fpu_done & w_fpu_busy & ~w_flush;
  // a completing unit can take a new op in the same cycle
  assign w_div_free = ~w_div_busy | w_div_done;
  assign w_fpu_free = ~w_fpu_busy | w_fpu_done;

  // Completion clears (bypassed into this cycle's checks) and watchdog clears (next edge only)
  always_comb begin
    w_clr_int     = '0;
    w_clr_fp      = '0;
    w_wdt_clr_int = '0;
    w_wdt_clr_fp  = '0;
    if (w_div_done & r_div_wi) w_clr_int[r_div_dest] = 1'b1;
    if (w_div_done & r_div_wf) w_clr_fp[r_div_dest]  = 1'b1;
    if (w_fpu_done & r_fpu_wi) w_clr_int[r_fpu_dest] = 1'b1;
    if (w_fpu_done & r_fpu_wf) w_clr_fp[r_fpu_dest]  = 1'b1;
    if (w_div_wdt_fire & r_div_wi) w_wdt_clr_int[r_div_dest] = 1'b1;
    if (w_div_wdt_fire & r_div_wf) w_wdt_clr_fp[r_div_dest]  = 1'b1;
    if (w_fpu_wdt_fire & r_fpu_wi) w_wdt_clr_int[r_fpu_dest] = 1'b1;
    if (w_fpu_wdt_fire & r_fpu_wf) w_wdt_clr_fp[r_fpu_dest]  = 1'b1;
  end

  assign w_ip_eff = r_int_pend & ~w_clr_int & X0_MASK;
  assign w_fp_eff = r_fp_pend & ~w_clr_fp;

  assign w_blocked0 = f_blocked(w_ip_eff, w_fp_eff,
    io_sb.s0_rden1, io_sb.s0_rden2, io_sb.s0_frden1, io_sb.s0_frden2, io_sb.s0_frden3,
    io_sb.s0_wren, io_sb.s0_fwren,
    io_sb.s0_raddr1, io_sb.s0_raddr2, io_sb.s0_raddr3, io_sb.s0_waddr,
    io_sb.s0_div, io_sb.s0_fpu, w_div_free, w_fpu_free);

  assign w_grant0 = io_sb.s0_valid & ~w_blocked0 & ~w_flush & ~i_reset;

  // Slot 1 cannot see slot 0's pending bit yet, so a long op on slot 0 is checked pair-wise here
  assign w_s0_long  = w_grant0 & (io_sb.s0_div | io_sb.s0_fpu);
  assign w_pair_int = io_sb.s0_wren & (io_sb.s0_waddr != '0) &
                      ((io_sb.s1_rden1 & (io_sb.s1_raddr1 == io_sb.s0_waddr)) |
                       (io_sb.s1_rden2 & (io_sb.s1_raddr2 == io_sb.s0_waddr)) |
                       (io_sb.s1_wren  & (io_sb.s1_waddr  == io_sb.s0_waddr)));
  assign w_pair_fp  = io_sb.s0_fwren &
                      ((io_sb.s1_frden1 & (io_sb.s1_raddr1 == io_sb.s0_waddr)) |
                       (io_sb.s1_frden2 & (io_sb.s1_raddr2 == io_sb.s0_waddr)) |
                       (io_sb.s1_frden3 & (io_sb.s1_raddr3 == io_sb.s0_waddr)) |
                       (io_sb.s1_fwren  & (io_sb.s1_waddr  == io_sb.s0_waddr)));
  assign w_same_unit = (io_sb.s0_div & io_sb.s1_div) | (io_sb.s0_fpu & io_sb.s1_fpu);

  assign w_blocked1 = f_blocked(w_ip_eff, w_fp_eff,
    io_sb.s1_rden1, io_sb.s1_rden2, io_sb.s1_frden1, io_sb.s1_frden2, io_sb.s1_frden3,
    io_sb.s1_wren, io_sb.s1_fwren,
    io_sb.s1_raddr1, io_sb.s1_raddr2, io_sb.s1_raddr3, io_sb.s1_waddr,
    io_sb.s1_div, io_sb.s1_fpu, w_div_free, w_fpu_free) |
    (w_s0_long & (w_pair_int | w_pair_fp)) | w_same_unit;

  // in-order: slot 1 only goes out together with slot 0
  assign w_grant1 = w_grant0 & io_sb.s1_valid & ~w_blocked1;
  assign w_stall  = ~w_flush & ~i_reset &
                    ((io_sb.s0_valid & ~w_grant0) | (io_sb.s1_valid & ~w_grant1));

  assign w_div_from_s0 = w_grant0 & io_sb.s0_div;
  assign w_fpu_from_s0 = w_grant0 & io_sb.s0_fpu;
  assign w_div_issue   = w_div_from_s0 | (w_grant1 & io_sb.s1_div);
  assign w_fpu_issue   = w_fpu_from_s0 | (w_grant1 & io_sb.s1_fpu);

  // Pending bits raised by granted long ops that write a register
  always_comb begin
    w_set_int = '0;
    w_set_fp  = '0;
    if (w_s0_long & io_sb.s0_wren & (io_sb.s0_waddr != '0)) w_set_int[io_sb.s0_waddr] = 1'b1;
    if (w_s0_long & io_sb.s0_fwren) w_set_fp[io_sb.s0_waddr] = 1'b1;
    if (w_grant1 & (io_sb.s1_div | io_sb.s1_fpu)) begin
      if (io_sb.s1_wren & (io_sb.s1_waddr != '0)) w_set_int[io_sb.s1_waddr] = 1'b1;
      if (io_sb.s1_fwren) w_set_fp[io_sb.s1_waddr] = 1'b1;
    end
  end

  // set wins over a same-cycle clear of the same bit
  assign w_int_pend_nxt = w_flush ? '0 : ((r_int_pend & ~(w_clr_int | w_wdt_clr_int)) | w_set_int);
  assign w_fp_pend_nxt  = w_flush ? '0 : ((r_fp_pend  & ~(w_clr_fp  | w_wdt_clr_fp))  | w_set_fp);

  // Unit FSM next state: flush, then new issue, then completion/watchdog
  always_comb begin
    w_div_state_nxt = r_div_state;
    w_fpu_state_nxt = r_fpu_state;
    if (w_flush)                           w_div_state_nxt = ST_IDLE;
    else if (w_div_issue)                  w_div_state_nxt = ST_BUSY;
    else if (w_div_done | w_div_wdt_fire)  w_div_state_nxt = ST_IDLE;
    if (w_flush)                           w_fpu_state_nxt = ST_IDLE;
    else if (w_fpu_issue)                  w_fpu_state_nxt = ST_BUSY;
    else if (w_fpu_done | w_fpu_wdt_fire)  w_fpu_state_nxt = ST_IDLE;
  end

  // Unit FSM and pending-bit registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_div_state <= ST_IDLE;
      r_fpu_state <= ST_IDLE;
      r_int_pend  <= '0;
      r_fp_pend   <= '0;
    end else begin
      r_div_state <= w_div_state_nxt;
      r_fpu_state <= w_fpu_state_nxt;
      r_int_pend  <= w_int_pend_nxt;
      r_fp_pend   <= w_fp_pend_nxt;
    end
  end

  // Remember which register each unit will free when it completes
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_div_dest <= '0;
      r_div_wi   <= 1'b0;
      r_div_wf   <= 1'b0;
      r_fpu_dest <= '0;
      r_fpu_wi   <= 1'b0;
      r_fpu_wf   <= 1'b0;
    end else begin
      if (w_div_issue) begin
        if (w_div_from_s0) begin
          r_div_dest <= io_sb.s0_waddr;
          r_div_wi   <= io_sb.s0_wren & (io_sb.s0_waddr != '0);
          r_div_wf   <= io_sb.s0_fwren;
        end else begin
          r_div_dest <= io_sb.s1_waddr;
          r_div_wi   <= io_sb.s1_wren & (io_sb.s1_waddr != '0);
          r_div_wf   <= io_sb.s1_fwren;
        end
      end
      if (w_fpu_issue) begin
        if (w_fpu_from_s0) begin
          r_fpu_dest <= io_sb.s0_waddr;
          r_fpu_wi   <= io_sb.s0_wren & (io_sb.s0_waddr != '0);
          r_fpu_wf   <= io_sb.s0_fwren;
        end else begin
          r_fpu_dest <= io_sb.s1_waddr;
          r_fpu_wi   <= io_sb.s1_wren & (io_sb.s1_waddr != '0);
          r_fpu_wf   <= io_sb.s1_fwren;
        end
      end
    end
  end

  // Saturating stall-cycle counter; only reset clears it
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                r_stall_cycles <= '0;
    else if (w_stall && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
  end

`ifdef ISSUE_SCOREBOARD_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_LIMIT + 1);
  logic [WDT_W-1:0] r_div_wdt, r_fpu_wdt;
  logic             r_wdt_error;

  // fires on the last of WDT_LIMIT consecutive busy cycles of one op
  assign w_div_wdt_fire = w_div_busy & ~w_div_done & ~w_flush & (r_div_wdt == WDT_W'(WDT_LIMIT - 1));
  assign w_fpu_wdt_fire = w_fpu_busy & ~w_fpu_done & ~w_flush & (r_fpu_wdt == WDT_W'(WDT_LIMIT - 1));

  // Busy-cycle counters restart for every new op and whenever the unit goes idle
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_div_wdt   <= '0;
      r_fpu_wdt   <= '0;
      r_wdt_error <= 1'b0;
    end else begin
      if ((w_div_state_nxt == ST_IDLE) || w_div_issue) r_div_wdt <= '0;
      else                                             r_div_wdt <= r_div_wdt + 1'b1;
      if ((w_fpu_state_nxt == ST_IDLE) || w_fpu_issue) r_fpu_wdt <= '0;
      else                                             r_fpu_wdt <= r_fpu_wdt + 1'b1;
      if (w_div_wdt_fire | w_fpu_wdt_fire) r_wdt_error <= 1'b1;
    end
  end

  assign io_sb.wdt_error = r_wdt_error;
`else
  logic [31:0] w_unused_wdt_limit;
  assign w_unused_wdt_limit = 32'(WDT_LIMIT);
  assign w_div_wdt_fire     = 1'b0;
  assign w_fpu_wdt_fire     = 1'b0;
  assign io_sb.wdt_error    = 1'b0;
`endif

  assign io_sb.grant0       = w_grant0;
  assign io_sb.grant1       = w_grant1;
  assign io_sb.stall        = w_stall;
  assign io_sb.div_kill     = w_flush & w_div_busy;
  assign io_sb.fpu_kill     = w_flush & w_fpu_busy;
  assign io_sb.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomised + directed bench for issue_scoreboard against an in-flight-op model.
// The model tracks each unit as an optional outstanding op record; pending = dests of ops in flight.
module tb_issue_scoreboard;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int PERF_W = 4;
  localparam int WDT_LIMIT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_scoreboard_if #(.AW(AW), .PERF_W(PERF_W)) bus ();
  issue_scoreboard #(.NREGS(NREGS), .AW(AW), .PERF_W(PERF_W), .WDT_LIMIT(WDT_LIMIT))
    dut (.i_clock(clk), .i_reset(rst), .io_sb(bus));

  typedef struct {
    bit valid, wren, fwren, rden1, rden2, frden1, frden2, frden3, div, fpu;
    int waddr, raddr1, raddr2, raddr3;
  } slot_t;
  typedef struct { bit busy; bit wi; bit wf; int dest; int wdt; } unit_t;

  slot_t s[2];
  bit    flush, div_done, fpu_done;
  unit_t u[2];           // 0 = divider, 1 = FPU
  bit    dn[2];
  bit    m_err;
  int    m_cnt;
  bit    e_g0, e_g1, e_stall, e_kd, e_kf;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    s[0] = '{default: 0};
    s[1] = '{default: 0};
    flush = 0; div_done = 0; fpu_done = 0;
  endtask

  task automatic drive();
    bus.flush = flush; bus.div_done = div_done; bus.fpu_done = fpu_done;
    bus.s0_valid = s[0].valid; bus.s0_wren = s[0].wren; bus.s0_fwren = s[0].fwren;
    bus.s0_waddr = AW'(s[0].waddr); bus.s0_rden1 = s[0].rden1; bus.s0_rden2 = s[0].rden2;
    bus.s0_frden1 = s[0].frden1; bus.s0_frden2 = s[0].frden2; bus.s0_frden3 = s[0].frden3;
    bus.s0_raddr1 = AW'(s[0].raddr1); bus.s0_raddr2 = AW'(s[0].raddr2);
    bus.s0_raddr3 = AW'(s[0].raddr3); bus.s0_div = s[0].div; bus.s0_fpu = s[0].fpu;
    bus.s1_valid = s[1].valid; bus.s1_wren = s[1].wren; bus.s1_fwren = s[1].fwren;
    bus.s1_waddr = AW'(s[1].waddr); bus.s1_rden1 = s[1].rden1; bus.s1_rden2 = s[1].rden2;
    bus.s1_frden1 = s[1].frden1; bus.s1_frden2 = s[1].frden2; bus.s1_frden3 = s[1].frden3;
    bus.s1_raddr1 = AW'(s[1].raddr1); bus.s1_raddr2 = AW'(s[1].raddr2);
    bus.s1_raddr3 = AW'(s[1].raddr3); bus.s1_div = s[1].div; bus.s1_fpu = s[1].fpu;
  endtask

  task automatic model_reset();
    u[0] = '{default: 0};
    u[1] = '{default: 0};
    m_err = 0;
    m_cnt = 0;
  endtask

  // a register is pending if some in-flight op (not finishing now) will write it
  function automatic bit pend(bit fp, int r);
    if (!fp && r == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (u[k].busy && !dn[k] && (fp ? u[k].wf : u[k].wi) && u[k].dest == r) return 1;
    return 0;
  endfunction

  function automatic bit ufree(int k);
    return !u[k].busy || dn[k];
  endfunction

  function automatic bit blocked(slot_t x);
    return (x.rden1 && pend(0, x.raddr1)) || (x.rden2 && pend(0, x.raddr2)) ||
           (x.frden1 && pend(1, x.raddr1)) || (x.frden2 && pend(1, x.raddr2)) ||
           (x.frden3 && pend(1, x.raddr3)) ||
           (x.wren && pend(0, x.waddr)) || (x.fwren && pend(1, x.waddr)) ||
           (x.div && !ufree(0)) || (x.fpu && !ufree(1));
  endfunction

  task automatic evaluate();
    bit dep;
    dn[0] = div_done && u[0].busy && !flush;
    dn[1] = fpu_done && u[1].busy && !flush;
    e_g0 = s[0].valid && !blocked(s[0]) && !flush;
    dep = 0;
    if (e_g0 && (s[0].div || s[0].fpu)) begin
      if (s[0].wren && s[0].waddr != 0)
        dep = (s[1].rden1 && s[1].raddr1 == s[0].waddr) || (s[1].rden2 && s[1].raddr2 == s[0].waddr) ||
              (s[1].wren && s[1].waddr == s[0].waddr);
      if (s[0].fwren)
        dep = dep || (s[1].frden1 && s[1].raddr1 == s[0].waddr) ||
              (s[1].frden2 && s[1].raddr2 == s[0].waddr) ||
              (s[1].frden3 && s[1].raddr3 == s[0].waddr) || (s[1].fwren && s[1].waddr == s[0].waddr);
    end
    if ((s[0].div && s[1].div) || (s[0].fpu && s[1].fpu)) dep = 1;
    e_g1 = e_g0 && s[1].valid && !blocked(s[1]) && !dep;
    e_stall = !flush && ((s[0].valid && !e_g0) || (s[1].valid && !e_g1));
    e_kd = flush && u[0].busy;
    e_kf = flush && u[1].busy;
  endtask

  task automatic check_outputs();
    chk("grant0", bus.grant0, e_g0);
    chk("grant1", bus.grant1, e_g1);
    chk("stall", bus.stall, e_stall);
    chk("div_kill", bus.div_kill, e_kd);
    chk("fpu_kill", bus.fpu_kill, e_kf);
    chk("stall_cycles", bus.stall_cycles, m_cnt);
`ifdef ISSUE_SCOREBOARD_WATCHDOG_EN
    chk("wdt_error", bus.wdt_error, m_err);
`else
    chk("wdt_error", bus.wdt_error, 0);
`endif
  endtask

  task automatic advance();
    for (int k = 0; k < 2; k++) begin
      bit i0, i1;
      i0 = e_g0 && (k == 0 ? s[0].div : s[0].fpu);
      i1 = e_g1 && (k == 0 ? s[1].div : s[1].fpu);
      if (flush) u[k] = '{default: 0};
      else if (i0 || i1) begin
        slot_t x;
        x = i0 ? s[0] : s[1];
        u[k] = '{busy: 1, wi: x.wren && x.waddr != 0, wf: x.fwren, dest: x.waddr, wdt: 0};
      end else if (dn[k]) u[k].busy = 0;
      else if (u[k].busy) begin
`ifdef ISSUE_SCOREBOARD_WATCHDOG_EN
        if (u[k].wdt == WDT_LIMIT - 1) begin u[k].busy = 0; m_err = 1; end
        else u[k].wdt++;
`endif
      end
    end
    if (e_stall && m_cnt < (1 << PERF_W) - 1) m_cnt++;
  endtask

  task automatic cyc_begin();
    drive();
    #1;
    evaluate();
    check_outputs();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  function automatic slot_t rnd_slot();
    slot_t x;
    int k;
    k = int'($urandom_range(0, 9));
    x.valid = ($urandom_range(0, 9) < 8);
    x.div = (k < 2);
    x.fpu = (k >= 2 && k < 4);
    x.wren = ($urandom_range(0, 1) == 1);
    x.fwren = !x.wren && ($urandom_range(0, 1) == 1);
    x.rden1 = ($urandom_range(0, 1) == 1);
    x.rden2 = ($urandom_range(0, 1) == 1);
    x.frden1 = ($urandom_range(0, 2) == 0);
    x.frden2 = ($urandom_range(0, 2) == 0);
    x.frden3 = ($urandom_range(0, 2) == 0);
    x.waddr = int'($urandom_range(0, 7));
    x.raddr1 = int'($urandom_range(0, 7));
    x.raddr2 = int'($urandom_range(0, 7));
    x.raddr3 = int'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic random_phase(int n);
    for (int i = 0; i < n; i++) begin
      s[0] = rnd_slot();
      s[1] = rnd_slot();
      flush = ($urandom_range(0, 49) == 0);
      div_done = ($urandom_range(0, 3) == 0);
      fpu_done = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle();
  endtask

  task automatic reset_checks();
    chk("rst_grant0", bus.grant0, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_stall_cycles", bus.stall_cycles, 0);
    chk("rst_wdt_error", bus.wdt_error, 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    s[0].valid = 1; s[0].rden1 = 1; s[0].raddr1 = 2;
    drive();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    idle();

    // divide to x5, dependent add waits until div_done bypasses the clear
    s[0] = '{valid: 1, wren: 1, waddr: 5, div: 1, rden1: 1, raddr1: 1, default: 0};
    cyc_begin(); chk("div_x5_grant", bus.grant0, 1); cyc_end();
    s[0] = '{valid: 1, rden1: 1, raddr1: 5, wren: 1, waddr: 6, default: 0};
    for (int i = 0; i < 3; i++) begin
      cyc_begin(); chk("raw_x5_hold", bus.grant0, 0); chk("raw_x5_stall", bus.stall, 1); cyc_end();
    end
    div_done = 1;
    cyc_begin(); chk("raw_x5_bypass", bus.grant0, 1); chk("raw_x5_nostall", bus.stall, 0); cyc_end();
    div_done = 0;
    cyc_begin(); chk("x5_cleared", bus.grant0, 1); cyc_end();

    // independent dual add
    s[0] = '{valid: 1, wren: 1, waddr: 1, rden1: 1, raddr1: 2, rden2: 1, raddr2: 3, default: 0};
    s[1] = '{valid: 1, wren: 1, waddr: 4, rden1: 1, raddr1: 6, rden2: 1, raddr2: 7, default: 0};
    cyc_begin(); chk("dual_g0", bus.grant0, 1); chk("dual_g1", bus.grant1, 1);
    chk("dual_stall", bus.stall, 0); cyc_end();

    // FPU op to f3 on s0, s1 reads f3 in the same pair
    s[0] = '{valid: 1, fwren: 1, waddr: 3, fpu: 1, frden1: 1, raddr1: 1, default: 0};
    s[1] = '{valid: 1, frden1: 1, raddr1: 3, fwren: 1, waddr: 4, default: 0};
    cyc_begin(); chk("pair_f3_g0", bus.grant0, 1); chk("pair_f3_g1", bus.grant1, 0);
    chk("pair_f3_stall", bus.stall, 1); cyc_end();
    idle();
    s[0] = '{valid: 1, frden2: 1, raddr2: 3, default: 0};
    cyc_begin(); chk("f3_pending", bus.grant0, 0); cyc_end();
    fpu_done = 1;
    cyc_begin(); chk("f3_bypass", bus.grant0, 1); cyc_end();

    // two divides in one pair
    idle();
    s[0] = '{valid: 1, wren: 1, waddr: 8, div: 1, default: 0};
    s[1] = '{valid: 1, wren: 1, waddr: 10, div: 1, default: 0};
    cyc_begin(); chk("dd_g0", bus.grant0, 1); chk("dd_g1", bus.grant1, 0); cyc_end();
    idle(); div_done = 1; cycle();

    // completion and re-issue to x7 in the same cycle: set wins
    idle();
    s[0] = '{valid: 1, wren: 1, waddr: 7, div: 1, default: 0};
    cycle();
    div_done = 1;
    cyc_begin(); chk("x7_reissue", bus.grant0, 1); cyc_end();
    idle();
    s[0] = '{valid: 1, rden2: 1, raddr2: 7, default: 0};
    cyc_begin(); chk("x7_still_pend", bus.grant0, 0); chk("x7_stall", bus.stall, 1); cyc_end();
    idle(); div_done = 1; cycle();

    // flush with div (x9) and FPU (f2) in flight
    idle();
    s[0] = '{valid: 1, wren: 1, waddr: 9, div: 1, default: 0};
    s[1] = '{valid: 1, fwren: 1, waddr: 2, fpu: 1, default: 0};
    cyc_begin(); chk("fl_issue_g0", bus.grant0, 1); chk("fl_issue_g1", bus.grant1, 1); cyc_end();
    idle();
    flush = 1; div_done = 1; fpu_done = 1;
    s[0] = '{valid: 1, rden1: 1, raddr1: 9, default: 0};
    cyc_begin(); chk("fl_div_kill", bus.div_kill, 1); chk("fl_fpu_kill", bus.fpu_kill, 1);
    chk("fl_grant0", bus.grant0, 0); chk("fl_stall", bus.stall, 0);
    chk("fl_cnt_before", bus.stall_cycles, 7); cyc_end();
    idle();
    s[0] = '{valid: 1, rden1: 1, raddr1: 9, default: 0};
    s[1] = '{valid: 1, frden3: 1, raddr3: 2, default: 0};
    cyc_begin(); chk("post_fl_g0", bus.grant0, 1); chk("post_fl_g1", bus.grant1, 1);
    chk("post_fl_kill", bus.div_kill, 0); chk("fl_cnt_after", bus.stall_cycles, 7); cyc_end();

    // divider that never completes
    idle();
    s[0] = '{valid: 1, wren: 1, waddr: 11, div: 1, default: 0};
    cycle();
    idle();
    repeat (WDT_LIMIT) cycle();
    s[0] = '{valid: 1, rden1: 1, raddr1: 11, default: 0};
    cyc_begin();
`ifdef ISSUE_SCOREBOARD_WATCHDOG_EN
    chk("wdt_fired", bus.wdt_error, 1); chk("wdt_x11_free", bus.grant0, 1);
`else
    chk("wdt_off", bus.wdt_error, 0); chk("hung_x11_hold", bus.grant0, 0);
`endif
    cyc_end();
    idle(); div_done = 1; cycle();

    random_phase(1500);
    cyc_begin(); chk("stall_cnt_saturated", bus.stall_cycles, 15); cyc_end();

    // asynchronous reset mid-run
    #2;
    rst = 1'b1;
    drive();
    model_reset();
    #1;
    reset_checks();
    @(negedge clk);
    rst = 1'b0;
    random_phase(1500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
